// File: rtl/freq_gate_counter.sv
// -----------------------------------------------------------------------------
// freq_gate_counter
//   Measures the frequency of an asynchronous signal by counting its rising
//   edges between consecutive gate ticks (1 Hz single-cycle pulses). At each
//   gate tick the closing window's count is latched with a one-cycle strobe.
//
// Ports:
//   iClk      system clock
//   irst      synchronous reset, active-low
//   iGate     gate tick, one cycle high marks a window boundary
//   iEnable   measurement enable (level)
//   iSignal   asynchronous signal under measurement
//   oFreq     rising-edge count of the last completed window (saturating)
//   oValid    one-cycle strobe: oFreq/oOverflow updated this cycle
//   oOverflow last completed window saturated the counter
//   oBusy     high while counting windows
// -----------------------------------------------------------------------------
module freq_gate_counter #(
  parameter int CNT_W       = 27,
  parameter int SYNC_STAGES = 2
) (
  input  logic             iClk,
  input  logic             irst,
  input  logic             iGate,
  input  logic             iEnable,
  input  logic             iSignal,
  output logic [CNT_W-1:0] oFreq,
  output logic             oValid,
  output logic             oOverflow,
  output logic             oBusy
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ARM   = 2'd1,
    COUNT = 2'd2
  } state_t;

  state_t                 r_state;
  logic [SYNC_STAGES-1:0] r_sync;
  logic                   r_hist;
  logic [CNT_W-1:0]       r_cnt;
  logic                   r_sticky;

  logic                   w_sync_out;
  logic                   w_edge;
  logic                   w_full;
  logic [CNT_W-1:0]       w_cnt_inc;
  logic [CNT_W-1:0]       w_close;
  logic                   w_close_ovf;

  assign w_sync_out  = r_sync[SYNC_STAGES-1];
  assign w_edge      = w_sync_out & ~r_hist;
  assign w_full      = (r_cnt == {CNT_W{1'b1}});
  assign w_cnt_inc   = r_cnt + {{(CNT_W-1){1'b0}}, 1'b1};
  // Value reported at a gate: an edge in the gate cycle still belongs to the
  // closing window, but may not wrap an already-saturated counter.
  assign w_close     = (w_edge && !w_full) ? w_cnt_inc : r_cnt;
  assign w_close_ovf = r_sticky | (w_edge & w_full);

  // Synchronizer chain for iSignal plus the edge-history flop.
  always_ff @(posedge iClk) begin
    if (!irst) begin
      r_sync <= {SYNC_STAGES{1'b0}};
      r_hist <= 1'b0;
    end else begin
      r_sync <= {r_sync[SYNC_STAGES-2:0], iSignal};
      r_hist <= w_sync_out;
    end
  end

  // Measurement FSM: window counter, overflow sticky and registered outputs.
  always_ff @(posedge iClk) begin
    if (!irst) begin
      r_state   <= IDLE;
      r_cnt     <= {CNT_W{1'b0}};
      r_sticky  <= 1'b0;
      oFreq     <= {CNT_W{1'b0}};
      oValid    <= 1'b0;
      oOverflow <= 1'b0;
      oBusy     <= 1'b0;
    end else begin
      oValid <= 1'b0;
      case (r_state)
        IDLE: begin
          r_cnt    <= {CNT_W{1'b0}};
          r_sticky <= 1'b0;
          oBusy    <= 1'b0;
          if (iEnable) begin
            r_state <= ARM;
          end
        end
        ARM: begin
          // The first gate only opens a window; nothing is reported.
          if (!iEnable) begin
            r_state <= IDLE;
          end else if (iGate) begin
            r_state  <= COUNT;
            r_cnt    <= {CNT_W{1'b0}};
            r_sticky <= 1'b0;
            oBusy    <= 1'b1;
          end
        end
        COUNT: begin
          // Enable is checked first: dropping it discards the partial window.
          if (!iEnable) begin
            r_state  <= IDLE;
            r_cnt    <= {CNT_W{1'b0}};
            r_sticky <= 1'b0;
            oBusy    <= 1'b0;
          end else if (iGate) begin
            oFreq     <= w_close;
            oOverflow <= w_close_ovf;
            oValid    <= 1'b1;
            r_cnt     <= {CNT_W{1'b0}};
            r_sticky  <= 1'b0;
          end else if (w_edge) begin
            if (w_full) begin
              r_sticky <= 1'b1;
            end else begin
              r_cnt <= w_cnt_inc;
            end
          end
        end
        default: begin
          r_state  <= IDLE;
          r_cnt    <= {CNT_W{1'b0}};
          r_sticky <= 1'b0;
          oBusy    <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_freq_gate_counter.sv
// -----------------------------------------------------------------------------
// tb_freq_gate_counter
//   Directed bench for freq_gate_counter. Two instances share all inputs: a
//   default-width one (a) and a 4-bit one (b) used for saturation behaviour.
// -----------------------------------------------------------------------------
module tb_freq_gate_counter;

  logic        iClk = 1'b0;
  logic        irst = 1'b0;
  logic        iGate = 1'b0;
  logic        iEnable = 1'b0;
  logic        iSignal = 1'b0;

  logic [26:0] freq_a;
  logic        valid_a, ovf_a, busy_a;
  logic [3:0]  freq_b;
  logic        valid_b, ovf_b, busy_b;

  int n_vec = 0;
  int n_err = 0;
  int nv_a  = 0;
  int nv_b  = 0;

  freq_gate_counter #(.CNT_W(27), .SYNC_STAGES(2)) dut_a (
    .iClk(iClk), .irst(irst), .iGate(iGate), .iEnable(iEnable),
    .iSignal(iSignal), .oFreq(freq_a), .oValid(valid_a),
    .oOverflow(ovf_a), .oBusy(busy_a)
  );

  freq_gate_counter #(.CNT_W(4), .SYNC_STAGES(2)) dut_b (
    .iClk(iClk), .irst(irst), .iGate(iGate), .iEnable(iEnable),
    .iSignal(iSignal), .oFreq(freq_b), .oValid(valid_b),
    .oOverflow(ovf_b), .oBusy(busy_b)
  );

  always #5 iClk = ~iClk;

  // One clock; outputs are sampled 1 ns after the rising edge.
  task automatic tick;
    @(posedge iClk);
    #1;
    if (valid_a === 1'b1) nv_a++;
    if (valid_b === 1'b1) nv_b++;
  endtask

  task automatic pulse(input int h, input int l);
    iSignal = 1'b1;
    repeat (h) tick();
    iSignal = 1'b0;
    repeat (l) tick();
  endtask

  task automatic gate;
    iGate = 1'b1;
    tick();
    iGate = 1'b0;
  endtask

  task automatic test_reset;
    irst    = 1'b0;
    iEnable = 1'b1;
    for (int i = 0; i < 3; i++) begin
      iSignal = ~iSignal;
      iGate   = ~iGate;
      tick();
      n_vec++; if (freq_a !== 27'd0) begin n_err++; $display("FAIL reset_freq[%0d]: got %0d want 0", i, freq_a); end
      n_vec++; if (valid_a !== 1'b0) begin n_err++; $display("FAIL reset_valid[%0d]: got %b want 0", i, valid_a); end
      n_vec++; if (ovf_a !== 1'b0) begin n_err++; $display("FAIL reset_ovf[%0d]: got %b want 0", i, ovf_a); end
      n_vec++; if (busy_a !== 1'b0) begin n_err++; $display("FAIL reset_busy[%0d]: got %b want 0", i, busy_a); end
    end
    iSignal = 1'b0;
    iGate   = 1'b0;
    iEnable = 1'b0;
    irst    = 1'b1;
    nv_a    = 0;
    repeat (4) tick();
    n_vec++; if (busy_a !== 1'b0) begin n_err++; $display("FAIL reset_idle_busy: got %b want 0", busy_a); end
    n_vec++; if (nv_a !== 0) begin n_err++; $display("FAIL reset_idle_valid: got %0d strobes want 0", nv_a); end
  endtask

  task automatic test_basic;
    iEnable = 1'b1;
    tick();                 // IDLE -> ARM
    gate();                 // t0: ARM -> COUNT
    n_vec++; if (valid_a !== 1'b0) begin n_err++; $display("FAIL basic_no_valid_t0p1: got %b want 0", valid_a); end
    n_vec++; if (busy_a !== 1'b1) begin n_err++; $display("FAIL basic_busy: got %b want 1", busy_a); end
    nv_a = 0;
    for (int i = 0; i < 37; i++) pulse(10, 10);
    repeat (999 - 740) tick();
    n_vec++; if (nv_a !== 0) begin n_err++; $display("FAIL basic_early_valid: got %0d strobes want 0", nv_a); end
    gate();                 // sampled at t0+1000, strobe visible at t0+1001
    n_vec++; if (valid_a !== 1'b1) begin n_err++; $display("FAIL basic_valid: got %b want 1", valid_a); end
    n_vec++; if (freq_a !== 27'd37) begin n_err++; $display("FAIL basic_freq: got %0d want 37", freq_a); end
    n_vec++; if (ovf_a !== 1'b0) begin n_err++; $display("FAIL basic_ovf: got %b want 0", ovf_a); end
    tick();
    n_vec++; if (valid_a !== 1'b0) begin n_err++; $display("FAIL basic_valid_one_cycle: got %b want 0", valid_a); end
  endtask

  task automatic test_boundary;
    for (int i = 0; i < 5; i++) pulse(4, 4);
    iSignal = 1'b1;
    tick();
    tick();                 // synchronized edge is active now
    gate();                 // gate sampled together with that edge
    n_vec++; if (valid_a !== 1'b1) begin n_err++; $display("FAIL boundary_valid: got %b want 1", valid_a); end
    n_vec++; if (freq_a !== 27'd6) begin n_err++; $display("FAIL boundary_freq: got %0d want 6", freq_a); end
    iSignal = 1'b0;
    repeat (4) tick();
    for (int i = 0; i < 4; i++) pulse(4, 4);
    gate();
    n_vec++; if (valid_a !== 1'b1) begin n_err++; $display("FAIL boundary_next_valid: got %b want 1", valid_a); end
    n_vec++; if (freq_a !== 27'd4) begin n_err++; $display("FAIL boundary_next_freq: got %0d want 4", freq_a); end
  endtask

  task automatic test_overflow;
    for (int i = 0; i < 20; i++) pulse(3, 3);
    gate();
    n_vec++; if (valid_b !== 1'b1) begin n_err++; $display("FAIL ovf_valid_b: got %b want 1", valid_b); end
    n_vec++; if (freq_b !== 4'd15) begin n_err++; $display("FAIL ovf_freq_b: got %0d want 15", freq_b); end
    n_vec++; if (ovf_b !== 1'b1) begin n_err++; $display("FAIL ovf_flag_b: got %b want 1", ovf_b); end
    n_vec++; if (freq_a !== 27'd20) begin n_err++; $display("FAIL ovf_freq_a: got %0d want 20", freq_a); end
    n_vec++; if (ovf_a !== 1'b0) begin n_err++; $display("FAIL ovf_flag_a: got %b want 0", ovf_a); end
    for (int i = 0; i < 3; i++) pulse(3, 3);
    gate();
    n_vec++; if (freq_b !== 4'd3) begin n_err++; $display("FAIL ovf_next_freq_b: got %0d want 3", freq_b); end
    n_vec++; if (ovf_b !== 1'b0) begin n_err++; $display("FAIL ovf_next_flag_b: got %b want 0", ovf_b); end
    n_vec++; if (freq_a !== 27'd3) begin n_err++; $display("FAIL ovf_next_freq_a: got %0d want 3", freq_a); end
  endtask

  task automatic test_enable_drop;
    nv_a = 0;
    for (int i = 0; i < 12; i++) pulse(3, 3);
    iEnable = 1'b0;
    tick();                 // COUNT -> IDLE
    n_vec++; if (busy_a !== 1'b0) begin n_err++; $display("FAIL drop_busy: got %b want 0", busy_a); end
    iEnable = 1'b1;
    tick();                 // IDLE -> ARM
    n_vec++; if (freq_a !== 27'd3) begin n_err++; $display("FAIL drop_freq_kept: got %0d want 3", freq_a); end
    for (int i = 0; i < 2; i++) pulse(3, 3);
    gate();                 // first gate after re-enable only arms
    n_vec++; if (nv_a !== 0) begin n_err++; $display("FAIL drop_no_valid: got %0d strobes want 0", nv_a); end
    n_vec++; if (busy_a !== 1'b1) begin n_err++; $display("FAIL drop_rearm_busy: got %b want 1", busy_a); end
    for (int i = 0; i < 7; i++) pulse(3, 3);
    gate();
    n_vec++; if (valid_a !== 1'b1) begin n_err++; $display("FAIL drop_second_valid: got %b want 1", valid_a); end
    n_vec++; if (freq_a !== 27'd7) begin n_err++; $display("FAIL drop_second_freq: got %0d want 7", freq_a); end
  endtask

  task automatic test_back_to_back;
    repeat (5) tick();
    iGate = 1'b1;
    tick();
    n_vec++; if (valid_a !== 1'b1) begin n_err++; $display("FAIL b2b_valid1: got %b want 1", valid_a); end
    n_vec++; if (freq_a !== 27'd0) begin n_err++; $display("FAIL b2b_freq1: got %0d want 0", freq_a); end
    tick();
    iGate = 1'b0;
    n_vec++; if (valid_a !== 1'b1) begin n_err++; $display("FAIL b2b_valid2: got %b want 1", valid_a); end
    n_vec++; if (freq_a !== 27'd0) begin n_err++; $display("FAIL b2b_freq2: got %0d want 0", freq_a); end
    n_vec++; if (ovf_a !== 1'b0) begin n_err++; $display("FAIL b2b_ovf: got %b want 0", ovf_a); end
    n_vec++; if (freq_b !== 4'd0) begin n_err++; $display("FAIL b2b_freq_b: got %0d want 0", freq_b); end
    tick();
    n_vec++; if (valid_a !== 1'b0) begin n_err++; $display("FAIL b2b_valid_end: got %b want 0", valid_a); end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_boundary();
    test_overflow();
    test_enable_drop();
    test_back_to_back();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
